de_lugish_exponential: RTL

//  Iterative shift-and-add antilogarithm. Inverse of the DeLugish log2 block.

---
 rtl/de_lugish_exponential_pkg.sv | 47 ++++
 rtl/de_lugish_exponential_if.sv | 24 ++
 rtl/de_lugish_exponential_lut.sv | 16 +
 rtl/de_lugish_exponential.sv | 107 ++++++++++
 4 files changed

// File: rtl/de_lugish_exponential_pkg.sv
// Shared constants, state type and antilog table for the LNS->linear block.
// Pure declarations; no timing of its own.
// The table is the iteration constant ROM shared with the log block.
package de_lugish_exponential_pkg;

  localparam int X_BITS = 8;
  localparam int Y_BITS = 12;
  localparam int GUARD  = 4;
  localparam int ITER   = X_BITS + 2;

  // Residual carries the input fraction plus guard bits.
  localparam int R_BITS = Y_BITS + GUARD;
  // Accumulator is 1 integer bit plus X_BITS+GUARD fraction bits.
  localparam int A_FRAC = X_BITS + GUARD;
  localparam int A_BITS = A_FRAC + 1;
  // Counter must also hold ITER+1, the "all iterations done" marker.
  localparam int I_BITS = $clog2(ITER + 2);

  localparam logic [A_BITS-1:0] A_ONE = {1'b1, {A_FRAC{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } exp_state_t;

  // L[i] = log2(1 + 2^-i), rounded to nearest at R_BITS (16) fraction bits.
  function automatic logic [R_BITS-1:0] exp_lut_value(input logic [I_BITS-1:0] idx);
    logic [R_BITS-1:0] v;
    v = '0;
    case (idx)
      4'd1:    v = 16'd38336;
      4'd2:    v = 16'd21098;
      4'd3:    v = 16'd11136;
      4'd4:    v = 16'd5732;
      4'd5:    v = 16'd2909;
      4'd6:    v = 16'd1466;
      4'd7:    v = 16'd736;
      4'd8:    v = 16'd369;
      4'd9:    v = 16'd184;
      4'd10:   v = 16'd92;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/de_lugish_exponential_if.sv
// Producer/consumer handshake bundle for the antilog block.
// No latency; wires only.
// Transfers occur when valid and enable are both high.
interface de_lugish_exponential_if;
  import de_lugish_exponential_pkg::*;

  logic [Y_BITS-1:0] data_in;
  logic              data_in_valid;
  logic              data_in_enable;
  logic [X_BITS-1:0] data_out;
  logic              data_out_valid;
  logic              data_out_enable;

  modport master (
    output data_in, data_in_valid, data_out_enable,
    input  data_in_enable, data_out, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid, data_out_enable,
    output data_in_enable, data_out, data_out_valid
  );

endinterface

// File: rtl/de_lugish_exponential_lut.sv
// Combinational ROM: iteration index i -> L[i] = log2(1+2^-i).
// Zero latency.
// No flow control; indices outside 1..ITER return 0.
module de_lugish_exp_lut
  import de_lugish_exponential_pkg::*;
(
  input  logic [I_BITS-1:0] idx,
  output logic [R_BITS-1:0] l_val
);

  // Table lookup through the shared package function.
  always_comb begin
    l_val = exp_lut_value(idx);
  end

endmodule

// File: rtl/de_lugish_exponential.sv
// Shift-and-add antilog: f in [0,1) -> 2^f - 1 at X_BITS fraction bits.
// Result valid ITER+1 edges after the accept edge; one operation in flight.
// Input enable drops while busy; the result is held until the consumer takes it.
module de_lugish_exponential
  import de_lugish_exponential_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  de_lugish_exponential_if.slave bus
);

  localparam int RND_BITS = A_BITS - GUARD + 1;
  localparam logic [RND_BITS-1:0] RND_TWO = RND_BITS'(1) << (X_BITS + 1);

  exp_state_t        state_q, state_d;
  logic [I_BITS-1:0] iter_q, iter_d;
  logic [R_BITS-1:0] res_q, res_d;
  logic [A_BITS-1:0] acc_q, acc_d;
  logic [X_BITS-1:0] dout_q, dout_d;
  logic              dvld_q, dvld_d;

  logic [R_BITS-1:0]   l_val;
  logic [A_BITS-1:0]   acc_shr;
  logic [RND_BITS-1:0] acc_rnd;
  logic                fire;
  logic                in_en;

  de_lugish_exp_lut u_lut (
    .idx  (iter_q),
    .l_val(l_val)
  );

  // Datapath helpers: subtract decision, shifted addend, half-up rounding.
  always_comb begin
    fire    = (res_q >= l_val);
    acc_shr = acc_q >> iter_q;
    acc_rnd = {1'b0, acc_q[A_BITS-1:GUARD]} + RND_BITS'(acc_q[GUARD-1]);
  end

  // Next-state and handshake logic; the counter runs to ITER+1 so the last
  // iteration has settled in acc_q before it is rounded.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    res_d   = res_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    dvld_d  = dvld_q;
    in_en   = 1'b0;
    case (state_q)
      IDLE: begin
        in_en = 1'b1;
        if (bus.data_in_valid) begin
          res_d   = {bus.data_in, {GUARD{1'b0}}};
          acc_d   = A_ONE;
          iter_d  = I_BITS'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (iter_q == I_BITS'(ITER + 1)) begin
          dout_d  = (acc_rnd >= RND_TWO) ? '1 : acc_rnd[X_BITS-1:0];
          dvld_d  = 1'b1;
          state_d = DONE;
        end else begin
          if (fire) begin
            res_d = res_q - l_val;
            acc_d = acc_q + acc_shr;
          end
          iter_d = iter_q + I_BITS'(1);
        end
      end
      DONE: begin
        if (bus.data_out_enable) begin
          dvld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      iter_q  <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
    end
  end

  // Enable is forced low while reset is held, even though the state is IDLE.
  assign bus.data_in_enable = in_en & ~rst;
  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = dvld_q;

endmodule
